// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: issues credit-limited requests to a registered
// instruction memory, buffers returned words with their PCs and hands them to
// decode over valid/ready. Redirects flush the buffer and kill in-flight data.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch/stall/redirect counters.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  output logic        imem_req,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StBoot, StRun, StRedir} state_e;

  state_e state_q, state_d;

  logic            inflight_q;
  logic [31:0]     inflight_pc_q;
  logic [31:0]     inst_mem_q [BUF_DEPTH];
  logic [31:0]     pc_mem_q   [BUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic redir_acc;
  logic pop;
  logic push;
  logic credit_ok;

  // Redirects are ignored while booting; an accepted one kills the word on imem_inst.
  assign redir_acc = redirect_valid && (state_q != StBoot);
  assign pop       = dec_valid && dec_ready;
  assign push      = inflight_q && !redir_acc;
  // count + inflight - pop < BUF_DEPTH, rearranged to stay unsigned.
  assign credit_ok = (32'(count_q) + 32'(inflight_q)) < (BUF_DEPTH + 32'(pop));

  assign dec_valid = (count_q != '0);
  assign dec_inst  = inst_mem_q[rd_ptr_q];
  assign dec_pc    = pc_mem_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StBoot;
    else     state_q <= state_d;
  end

  // Next-state: BOOT falls through to RUN; every accepted redirect (re)enters REDIR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:         state_d = StRun;
      StRun, StRedir: state_d = redir_acc ? StRedir : StRun;
      default:        state_d = StBoot;
    endcase
  end

  // Request output: issue whenever the buffer can absorb the returning word.
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      StRun, StRedir: imem_req = !redirect_valid && credit_ok;
      default:        imem_req = 1'b0;
    endcase
  end

  // Fetch PC and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_pc       <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) inflight_pc_q <= imem_pc;
      if (redir_acc) begin
        imem_pc <= redirect_pc & ~32'h3;
      end else if (imem_req) begin
        imem_pc <= imem_pc + 32'd4;
      end
    end
  end

  // Instruction FIFO; a redirect clears it regardless of push/pop this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redir_acc) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        inst_mem_q[wr_ptr_q] <= imem_inst;
        pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt    <= '0;
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (pop)                    perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (dec_valid && !dec_ready) perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (redir_acc)              perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic        imem_req;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt;
`endif

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_pc       (imem_pc),
    .imem_req      (imem_req),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Registered instruction memory: word = pc ^ KEY, one cycle after the request.
  logic [31:0] mem_q = '0;
  always @(posedge clk) if (imem_req) mem_q <= imem_pc ^ KEY;
  assign imem_inst = mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: words ready for decode, one word in flight, next fetch PC.
  bit          m_boot;
  logic [31:0] m_fpc, m_ipc;
  bit          m_infl;
  logic [31:0] m_q[$];
  int          m_acc, m_stall, m_redir;

  task automatic model_reset();
    m_boot = 1; m_fpc = 32'h0; m_ipc = 32'h0; m_infl = 0; m_q.delete();
    m_acc = 0; m_stall = 0; m_redir = 0;
  endtask

  // Compare current outputs with the model, then advance the model across the edge.
  task automatic model_step();
    bit ev, pop, redir, er;
    ev    = (m_q.size() != 0);
    pop   = ev && dec_ready;
    redir = redirect_valid && !m_boot;
    er    = !m_boot && !redirect_valid && (m_q.size() + int'(m_infl) < int'(DEPTH) + int'(pop));
    chk("m_dec_valid", dec_valid, ev);
    chk("m_imem_req", imem_req, er);
    if (er) chk("m_imem_pc", imem_pc, m_fpc);
    if (ev) begin
      chk("m_dec_pc", dec_pc, m_q[0]);
      chk("m_dec_inst", dec_inst, m_q[0] ^ KEY);
    end
    if (pop) m_acc++;
    if (ev && !dec_ready) m_stall++;
    if (redir) m_redir++;
    if (m_boot) begin
      m_boot = 0;
    end else if (redir) begin
      m_q.delete();
      m_infl = 0;
      m_fpc  = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_ipc);
      m_infl = er;
      if (er) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  // Called at a falling edge; leaves time 1 unit later with inputs settled.
  task automatic step_in(input bit rdy, input bit rv, input logic [31:0] rpc);
    dec_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic step_end();
    model_step();
    @(negedge clk);
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    step_in(rdy, rv, rpc);
    step_end();
  endtask

  // Asserts reset, checks reset values, releases at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dec_ready = 0; redirect_valid = 0; redirect_pc = '0;
    #1;
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
    chk("rst_perf_redir", perf_redirect_cnt, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // With dec_ready=1, expect the next two presented PCs to be first, first+4.
  task automatic expect_stream(input logic [31:0] first, input string name);
    int seen = 0;
    for (int i = 0; i < 12 && seen < 2; i++) begin
      step_in(1, 0, 32'h0);
      if (dec_valid) begin
        if (seen == 0) chk({name, "_first"}, dec_pc, first);
        else           chk({name, "_second"}, dec_pc, first + 32'd4);
        seen++;
      end
      step_end();
    end
    if (seen < 2) chk({name, "_timeout"}, 32'(seen), 32'd2);
  endtask

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] edpc;
    bit          er;
    logic [31:0] eipc;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Cycle-by-cycle from reset release: stream, 6-cycle stall, redirect to 0x100.
    tbl[0]  = '{1, 0, 32'h0,   0, 32'h0,   0, 32'h0};
    tbl[1]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h0};
    tbl[2]  = '{0, 0, 32'h0,   0, 32'h0,   1, 32'h4};
    tbl[3]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[4]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[5]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[6]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[7]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[8]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[9]  = '{1, 0, 32'h0,   1, 32'h0,   1, 32'h8};
    tbl[10] = '{1, 0, 32'h0,   1, 32'h4,   1, 32'hC};
    tbl[11] = '{1, 0, 32'h0,   1, 32'h8,   1, 32'h10};
    tbl[12] = '{0, 1, 32'h100, 1, 32'hC,   0, 32'h0};
    tbl[13] = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h100};
    tbl[14] = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h104};
    tbl[15] = '{1, 0, 32'h0,   1, 32'h100, 1, 32'h108};
    tbl[16] = '{1, 0, 32'h0,   1, 32'h104, 1, 32'h10C};

    model_reset();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step_in(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("tbl%0d_dec_valid", i), dec_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_imem_req", i), imem_req, tbl[i].er);
      if (tbl[i].ev) chk($sformatf("tbl%0d_dec_pc", i), dec_pc, tbl[i].edpc);
      if (tbl[i].er) chk($sformatf("tbl%0d_imem_pc", i), imem_pc, tbl[i].eipc);
      step_end();
    end

    // Redirect with the buffer full: nothing older than the target is presented.
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0);
    chk("full_before_redir", dec_valid, 1'b1);
    step(0, 1, 32'h200);
    expect_stream(32'h200, "redir_full");

    // Misaligned target and PC wrap-around.
    step(1, 1, 32'h103);
    expect_stream(32'h100, "redir_align");
    step(1, 1, 32'hFFFF_FFFC);
    expect_stream(32'hFFFF_FFFC, "redir_wrap");

    // Back-to-back redirects: the last one wins.
    step(1, 1, 32'h400);
    step(1, 1, 32'h500);
    expect_stream(32'h500, "redir_b2b");

    // Redirect during BOOT is ignored: fetch starts at the reset PC.
    do_reset();
    step(1, 1, 32'h300);
    step_in(1, 0, 32'h0);
    chk("boot_redir_req", imem_req, 1'b1);
    chk("boot_redir_pc", imem_pc, 32'h0);
    step_end();

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
    end

`ifdef FETCH_PERF_CNT_EN
    // Counters against bench tallies, then an asynchronous reset mid-run.
    do_reset();
    for (int i = 0; i < 60; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom());
    step_in(1, 0, 32'h0);
    chk("perf_fetch", perf_fetch_cnt, 32'(m_acc));
    chk("perf_stall", perf_stall_cnt, 32'(m_stall));
    chk("perf_redir", perf_redirect_cnt, 32'(m_redir));
    step_end();
    step_in(1, 0, 32'h0);
    rst = 1'b1;
    #1;
    chk("midrst_dec_valid", dec_valid, 1'b0);
    chk("midrst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("midrst_perf_stall", perf_stall_cnt, 32'h0);
    chk("midrst_perf_redir", perf_redirect_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
